// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package   : mem_arb_pkg
// Purpose   : Shared encodings and default widths for the memory port arbiter
//             (FSM state, transaction owner, starve counter width).
// Revision  : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int c_ADDR_W_DEF    = 16;
  localparam int c_DATA_W_DEF    = 16;
  localparam int c_STARVE_CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : arb_starve_ctr
// Purpose   : Counts data grants issued while a fetch is waiting and raises
//             force_if once the count saturates at STARVE_MAX, so the fetch
//             port wins the next contested arbitration.
// Revision  : 1.0 - initial release
// ============================================================================
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_gnt,
  input  logic if_gnt,
  input  logic if_req,
  input  logic idle,
  output logic force_if
);

  localparam logic [c_STARVE_CNT_W-1:0] c_MAX = c_STARVE_CNT_W'(STARVE_MAX);

  logic [c_STARVE_CNT_W-1:0] r_cnt;

  // Saturating count of data grants that bypassed a pending fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (if_gnt || (idle && !if_req)) begin
      r_cnt <= '0;
    end else if (d_gnt && if_req && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign force_if = (r_cnt == c_MAX);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : mem_port_arbiter
// Purpose   : Serialises instruction-fetch and data accesses onto a single
//             ported memory. Data has fixed priority; a fetch in flight when
//             flush arrives completes on memory but its response is dropped.
//             Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = c_ADDR_W_DEF,
  parameter int DATA_W     = c_DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // WAIT runs its counter 0..MEM_LAT-2; keep at least one bit when unused
  localparam int c_CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int c_WAIT_LAST = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  arb_owner_e          r_owner;
  logic                r_we;
  logic                r_drop;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_CNT_W-1:0]  r_wcnt;
  logic                w_idle;
  logic                w_force_if;
  logic                w_pick_d;
  logic                w_resp;

  assign w_idle = (r_state == ST_IDLE);

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_gnt    (d_gnt),
    .if_gnt   (if_gnt),
    .if_req   (if_req),
    .idle     (w_idle),
    .force_if (w_force_if)
  );
`else
  logic w_unused_starve;
  assign w_force_if      = 1'b0;
  assign w_unused_starve = (STARVE_MAX == 0);
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grants and response outputs; rst_n gates everything to 0
  always_comb begin
    w_state_nxt = r_state;
    w_pick_d    = d_req && !(w_force_if && if_req);
    d_gnt       = rst_n && w_idle && w_pick_d;
    if_gnt      = rst_n && w_idle && if_req && !w_pick_d;
    w_resp      = rst_n && (r_state == ST_RESP);
    if_rvalid   = w_resp && (r_owner == OWN_IF) && !r_drop && !flush;
    d_rvalid    = w_resp && (r_owner == OWN_D);
    if_rdata    = if_rvalid ? mem_rdata : '0;
    d_rdata     = (d_rvalid && !r_we) ? mem_rdata : '0;

    case (r_state)
      ST_IDLE:   if (if_gnt || d_gnt) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = (MEM_LAT == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (r_wcnt == c_CNT_W'(c_WAIT_LAST)) w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory latency counter, only advancing while in WAIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wcnt <= r_wcnt + 1'b1;
    end else begin
      r_wcnt <= '0;
    end
  end

  // Capture the winning request at grant; release ownership after response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (d_gnt) begin
      r_owner <= OWN_D;
      r_we    <= d_we;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
    end else if (if_gnt) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= if_addr;
      r_wdata <= '0;
    end else if (r_state == ST_RESP) begin
      r_owner <= OWN_NONE;
    end
  end

  // Flush marks an in-flight (or just-granted) fetch as stale until IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop <= 1'b0;
    end else if (r_state == ST_RESP) begin
      r_drop <= 1'b0;
    end else if (flush && (if_gnt || (!w_idle && (r_owner == OWN_IF)))) begin
      r_drop <= 1'b1;
    end
  end

  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = !w_idle;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_mem_port_arbiter
// Purpose   : Self-checking bench. Two arbiters (MEM_LAT=1 and MEM_LAT=4)
//             share stimulus; a scoreboard predicts every response at grant
//             time and checks it on the cycle it is due.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 4;

  typedef struct {
    int          inst;
    bit          is_d;
    logic [15:0] data;
    int          due;
    bit          drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_req;
  logic [15:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;

  logic        if_gnt_a    [2];
  logic        if_rvalid_a [2];
  logic [15:0] if_rdata_a  [2];
  logic        d_gnt_a     [2];
  logic        d_rvalid_a  [2];
  logic [15:0] d_rdata_a   [2];
  logic        mem_en_a    [2];
  logic        mem_we_a    [2];
  logic [15:0] mem_addr_a  [2];
  logic [15:0] mem_wdata_a [2];
  logic [15:0] mem_rdata_a [2];
  logic        busy_a      [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a[0] || busy_a[1]) && n < 100) begin
      nxt();
      n++;
    end
    chk("idle_wait", 0, 32'({busy_a[0], busy_a[1]}), 32'd0);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? LAT0 : LAT1;
    int          rd_cnt = 0;
    logic [15:0] rd_dat = '0;

    mem_port_arbiter #(
      .ADDR_W     (16),
      .DATA_W     (16),
      .MEM_LAT    (LAT),
      .STARVE_MAX (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt_a[g]),
      .if_rvalid (if_rvalid_a[g]),
      .if_rdata  (if_rdata_a[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_a[g]),
      .d_rvalid  (d_rvalid_a[g]),
      .d_rdata   (d_rdata_a[g]),
      .mem_en    (mem_en_a[g]),
      .mem_we    (mem_we_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_wdata (mem_wdata_a[g]),
      .mem_rdata (mem_rdata_a[g]),
      .busy      (busy_a[g])
    );

    // Memory model: read data valid exactly LAT cycles after mem_en
    always @(posedge clk) begin
      if (mem_en_a[g] && !mem_we_a[g]) begin
        rd_cnt <= LAT;
        rd_dat <= mem_fn(mem_addr_a[g]);
      end else if (rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
      end
    end

    assign mem_rdata_a[g] = (rd_cnt == 1) ? rd_dat : 16'hDEAD;
  end

  // Scoreboard: push on grant, pop and compare on the due cycle
  always @(negedge clk) begin
    int   hi;
    bit   due;
    bit   exp_ifv;
    bit   exp_dv;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      hi = -1;
      for (int j = 0; j < sb.size(); j++) begin
        if (sb[j].inst == k && hi < 0) hi = j;
      end
      if (!rst_n) begin
        chk("rst_rvalid", k, 32'({if_rvalid_a[k], d_rvalid_a[k]}), 32'd0);
      end else begin
        if (if_gnt_a[k] || d_gnt_a[k]) begin
          chk("gnt_excl", k, 32'(if_gnt_a[k] && d_gnt_a[k]), 32'd0);
          chk("gnt_busy", k, 32'(hi >= 0), 32'd0);
          e.inst = k;
          e.is_d = d_gnt_a[k];
          e.data = d_gnt_a[k] ? (d_we ? 16'h0000 : mem_fn(d_addr)) : mem_fn(if_addr);
          e.due  = cyc + 1 + lat_of(k);
          e.drop = 1'b0;
          sb.push_back(e);
          if (hi < 0) hi = sb.size() - 1;
        end
        if (flush && hi >= 0 && !sb[hi].is_d) sb[hi].drop = 1'b1;
        due = (hi >= 0) && (sb[hi].due == cyc);
        if (due || if_rvalid_a[k] || d_rvalid_a[k]) begin
          exp_ifv = due && !sb[hi].is_d && !sb[hi].drop;
          exp_dv  = due && sb[hi].is_d;
          chk("if_rvalid", k, 32'(if_rvalid_a[k]), 32'(exp_ifv));
          chk("d_rvalid",  k, 32'(d_rvalid_a[k]),  32'(exp_dv));
          chk("if_rdata",  k, 32'(if_rdata_a[k]),  exp_ifv ? 32'(sb[hi].data) : 32'd0);
          chk("d_rdata",   k, 32'(d_rdata_a[k]),   exp_dv  ? 32'(sb[hi].data) : 32'd0);
          if (due) sb.delete(hi);
        end
      end
    end
    if (!rst_n) sb.delete();
  end

  initial begin
    int ord [6];
    int exp_ord [6];
    int cnt;
    int n;
    bit got;

    rst_n = 1'b0; flush = 1'b0;
    if_req = 1'b1; if_addr = 16'h0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; d_wdata = 16'h0000;

    // 1. reset with both requests asserted
    repeat (3) begin
      nxt();
      smp();
      for (int k = 0; k < 2; k++) begin
        chk("rst_flags", k, 32'({if_gnt_a[k], if_rvalid_a[k], d_gnt_a[k], d_rvalid_a[k],
                                 mem_en_a[k], mem_we_a[k], busy_a[k]}), 32'd0);
        chk("rst_rdata", k, {if_rdata_a[k], d_rdata_a[k]}, 32'd0);
        chk("rst_mem",   k, {mem_addr_a[k], mem_wdata_a[k]}, 32'd0);
      end
    end
    nxt();
    rst_n = 1'b1;
    smp();
    for (int k = 0; k < 2; k++) begin
      chk("rel_dgnt",  k, 32'(d_gnt_a[k]), 32'd1);
      chk("rel_ifgnt", k, 32'(if_gnt_a[k]), 32'd0);
    end
    nxt();
    d_req = 1'b0; if_req = 1'b0;
    wait_idle();

    // 2. lone fetch on the MEM_LAT=1 arbiter
    if_req = 1'b1; if_addr = 16'h0010;
    smp();
    chk("t2_ifgnt", 0, 32'(if_gnt_a[0]), 32'd1);
    nxt();
    if_req = 1'b0;
    smp();
    chk("t2_men",   0, 32'(mem_en_a[0]), 32'd1);
    chk("t2_maddr", 0, 32'(mem_addr_a[0]), 32'h0010);
    chk("t2_mwe",   0, 32'(mem_we_a[0]), 32'd0);
    nxt();
    smp();
    chk("t2_rvalid", 0, 32'(if_rvalid_a[0]), 32'd1);
    chk("t2_rdata",  0, 32'(if_rdata_a[0]), 32'hA5A5);
    wait_idle();

    // 3. simultaneous fetch and store: data wins, fetch follows
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    smp();
    chk("t3_dgnt",  0, 32'(d_gnt_a[0]), 32'd1);
    chk("t3_ifgnt", 0, 32'(if_gnt_a[0]), 32'd0);
    nxt();
    d_req = 1'b0;
    smp();
    chk("t3_mwe",    0, 32'(mem_we_a[0]), 32'd1);
    chk("t3_mwdata", 0, 32'(mem_wdata_a[0]), 32'h1234);
    chk("t3_maddr",  0, 32'(mem_addr_a[0]), 32'h0100);
    nxt();
    smp();
    chk("t3_drv",    0, 32'({d_rvalid_a[0], d_rdata_a[0]}), 32'h10000);
    chk("t3_noif",   0, 32'(if_gnt_a[0]), 32'd0);
    nxt();
    smp();
    chk("t3_ifgnt2", 0, 32'(if_gnt_a[0]), 32'd1);
    nxt();
    if_req = 1'b0; d_we = 1'b0;
    wait_idle();

    // 4. flush one cycle after a fetch grant on the MEM_LAT=4 arbiter
    if_req = 1'b1; if_addr = 16'h0030;
    smp();
    chk("t4_ifgnt", 1, 32'(if_gnt_a[1]), 32'd1);
    nxt();
    if_req = 1'b0; flush = 1'b1;
    smp();
    chk("t4_men", 1, 32'(mem_en_a[1]), 32'd1);
    nxt();
    flush = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      smp();
      chk("t4_norv", 1, 32'(if_rvalid_a[1]), 32'd0);
      nxt();
    end
    chk("t4_busy", 1, 32'(busy_a[1]), 32'd0);
    wait_idle();

    // 4b. flush coinciding with the response cycle of a fetch
    if_req = 1'b1; if_addr = 16'h0034;
    smp();
    chk("t4b_ifgnt", 0, 32'(if_gnt_a[0]), 32'd1);
    nxt();
    if_req = 1'b0;
    nxt();
    flush = 1'b1;
    smp();
    chk("t4b_busy", 0, 32'(busy_a[0]), 32'd1);
    chk("t4b_norv", 0, 32'(if_rvalid_a[0]), 32'd0);
    nxt();
    flush = 1'b0;
    wait_idle();

    // 4c. flush has no effect on a data load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    smp();
    chk("t4c_dgnt", 0, 32'(d_gnt_a[0]), 32'd1);
    nxt();
    d_req = 1'b0; flush = 1'b1;
    nxt();
    flush = 1'b0;
    smp();
    chk("t4c_drv", 0, 32'({d_rvalid_a[0], d_rdata_a[0]}), 32'h1A7B5);
    wait_idle();

    // 5. both ports held: observe grant order
    if_req = 1'b1; if_addr = 16'h0060;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
`ifdef ARB_STARVE_GUARD_EN
    exp_ord = '{1, 1, 1, 1, 2, 1};
`else
    exp_ord = '{1, 1, 1, 1, 1, 1};
`endif
    cnt = 0; n = 0;
    while (cnt < 6 && n < 200) begin
      smp();
      if (d_gnt_a[0]) begin
        ord[cnt] = 1; cnt++;
      end else if (if_gnt_a[0]) begin
        ord[cnt] = 2; cnt++;
      end
      nxt();
      n++;
    end
    chk("t5_count", 0, 32'(cnt), 32'd6);
    for (int i = 0; i < 6; i++) chk("t5_order", i, 32'(ord[i]), 32'(exp_ord[i]));
    d_req = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 50) begin
      smp();
      got = if_gnt_a[0];
      nxt();
      n++;
    end
    chk("t5_ifafter", 0, 32'(got), 32'd1);
    if_req = 1'b0;
    wait_idle();

    // 6. reset in the middle of WAIT on the MEM_LAT=4 arbiter
    if_req = 1'b1; if_addr = 16'h0040;
    smp();
    chk("t6_ifgnt", 1, 32'(if_gnt_a[1]), 32'd1);
    nxt();
    if_req = 1'b0;
    nxt();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    smp();
    chk("t6_busy", 1, 32'(busy_a[1]), 32'd0);
    chk("t6_busy", 0, 32'(busy_a[0]), 32'd0);
    repeat (6) nxt();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    smp();
    chk("t6_dgnt", 1, 32'(d_gnt_a[1]), 32'd1);
    nxt();
    d_req = 1'b0;
    wait_idle();
    repeat (2) nxt();
    chk("sb_empty", 0, 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
